meter_display_driver: RTL

Downstream display stage for `parking_meter`. It takes the four BCD digits of remaining time (`val1`..`val4`) plus a blink mode, and time-multiplexes them onto one shared active-low 7-segment bus with four active-low anode enables. It owns the digit-scan state machine, the blink phase generator, BCD-to-segment decoding and optional leading-zero blanking.

---
 rtl/meter_display_pkg.sv | 53 +++++
 rtl/meter_display_driver_if.sv | 23 ++
 rtl/meter_display_driver_seg7_decode.sv | 26 ++
 rtl/meter_display_driver.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/meter_display_pkg.sv
// Shared types and constants for the meter display driver: segment patterns,
// blink-mode encodings and the digit-scan state type.
package meter_display_pkg;

    typedef enum logic [1:0] {
        DIG1 = 2'd0,
        DIG2 = 2'd1,
        DIG3 = 2'd2,
        DIG4 = 2'd3
    } digit_state_t;

    localparam logic [1:0] BLINK_STEADY = 2'b00;
    localparam logic [1:0] BLINK_FAST   = 2'b01;
    localparam logic [1:0] BLINK_SLOW   = 2'b10;

    // Active-low patterns, bit0 = segment a ... bit6 = segment g.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic digit_state_t next_digit(input digit_state_t s);
        digit_state_t n;
        case (s)
            DIG1:    n = DIG2;
            DIG2:    n = DIG3;
            DIG3:    n = DIG4;
            default: n = DIG1;
        endcase
        return n;
    endfunction

    // Active-low anode vector, bit0 = a1 (leftmost).
    function automatic logic [3:0] anode_sel(input digit_state_t s);
        logic [3:0] an;
        case (s)
            DIG1:    an = 4'b1110;
            DIG2:    an = 4'b1101;
            DIG3:    an = 4'b1011;
            default: an = 4'b0111;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/meter_display_driver_if.sv
// Digit/blink inputs and multiplexed segment/anode outputs of the meter display.
interface meter_display_driver_if;
    logic [3:0] val1;
    logic [3:0] val2;
    logic [3:0] val3;
    logic [3:0] val4;
    logic [1:0] blink_mode;
    logic [6:0] led_seg;
    logic       a1;
    logic       a2;
    logic       a3;
    logic       a4;

    modport master (
        output val1, val2, val3, val4, blink_mode,
        input  led_seg, a1, a2, a3, a4
    );

    modport slave (
        input  val1, val2, val3, val4, blink_mode,
        output led_seg, a1, a2, a3, a4
    );
endinterface

// File: rtl/meter_display_driver_seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 show a dash.
module seg7_decode
    import meter_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/meter_display_driver.sv
// Four-digit multiplexed 7-segment driver with blink phase generator.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
//
// state | meaning
// DIG1  | driving a1 (thousands)
// DIG2  | driving a2 (hundreds)
// DIG3  | driving a3 (tens)
// DIG4  | driving a4 (units)
module meter_display_driver
    import meter_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_HALF  = 50000000
) (
    input  logic                   clk,
    input  logic                   rst,
    meter_display_driver_if.slave  bus
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(4 * BLINK_HALF);

    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] HALF_C    = BW'(BLINK_HALF);
    localparam logic [BW-1:0] FULL_C    = BW'(2 * BLINK_HALF);
    localparam logic [BW-1:0] FAST_LAST = BW'(2 * BLINK_HALF - 1);
    localparam logic [BW-1:0] SLOW_LAST = BW'(4 * BLINK_HALF - 1);

    digit_state_t  r_state;
    digit_state_t  w_state_nxt;
    logic [RW-1:0] r_refresh;
    logic [BW-1:0] r_blink;
    logic [BW-1:0] w_blink_nxt;
    logic [1:0]    r_mode_q;
    logic [3:0]    r_digit;
    logic [3:0]    w_digit_nxt;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;
    logic [6:0]    w_seg_dec;
    logic [6:0]    w_seg_nxt;
    logic [3:0]    w_an_nxt;
    logic          w_boundary;
    logic          w_visible;
    logic          w_lz_blank;

    assign w_boundary = (r_refresh == REF_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DIG1;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The digit for the upcoming slot is captured on the same edge the FSM
    // enters it, so the input is never re-sampled mid-slot.
    always_comb begin
        w_state_nxt = r_state;
        w_digit_nxt = r_digit;
        if (w_boundary) begin
            w_state_nxt = next_digit(r_state);
            case (w_state_nxt)
                DIG1:    w_digit_nxt = bus.val1;
                DIG2:    w_digit_nxt = bus.val2;
                DIG3:    w_digit_nxt = bus.val3;
                default: w_digit_nxt = bus.val4;
            endcase
        end
    end

    always_comb begin
        w_blink_nxt = r_blink;
        w_visible   = 1'b1;
        if (bus.blink_mode != r_mode_q) begin
            w_blink_nxt = '0;
        end else begin
            case (r_mode_q)
                BLINK_STEADY: w_blink_nxt = '0;
                BLINK_FAST:   w_blink_nxt = (r_blink >= FAST_LAST) ? '0 : r_blink + BW'(1);
                default:      w_blink_nxt = (r_blink >= SLOW_LAST) ? '0 : r_blink + BW'(1);
            endcase
        end
        case (r_mode_q)
            BLINK_STEADY: w_visible = 1'b1;
            BLINK_FAST:   w_visible = (r_blink < HALF_C);
            default:      w_visible = (r_blink < FULL_C);
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Units digit is never blanked, so only the upper three are snapshotted.
    logic [3:0] r_snap1;
    logic [3:0] r_snap2;
    logic [3:0] r_snap3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap1 <= '0;
            r_snap2 <= '0;
            r_snap3 <= '0;
        end else if (w_boundary && (w_state_nxt == DIG1)) begin
            r_snap1 <= bus.val1;
            r_snap2 <= bus.val2;
            r_snap3 <= bus.val3;
        end
    end

    always_comb begin
        w_lz_blank = 1'b0;
        case (r_state)
            DIG1:    w_lz_blank = (r_snap1 == 4'd0);
            DIG2:    w_lz_blank = (r_snap1 == 4'd0) && (r_snap2 == 4'd0);
            DIG3:    w_lz_blank = (r_snap1 == 4'd0) && (r_snap2 == 4'd0) && (r_snap3 == 4'd0);
            default: w_lz_blank = 1'b0;
        endcase
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    seg7_decode u_decode (
        .i_bcd (r_digit),
        .o_seg (w_seg_dec)
    );

    always_comb begin
        w_an_nxt  = 4'b1111;
        w_seg_nxt = SEG_BLANK;
        if (w_visible) begin
            w_an_nxt  = anode_sel(r_state);
            w_seg_nxt = w_lz_blank ? SEG_BLANK : w_seg_dec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh <= '0;
            r_blink   <= '0;
            r_mode_q  <= BLINK_STEADY;
            r_digit   <= '0;
            r_seg     <= SEG_BLANK;
            r_an      <= 4'b1111;
        end else begin
            r_refresh <= w_boundary ? '0 : r_refresh + RW'(1);
            r_blink   <= w_blink_nxt;
            r_mode_q  <= bus.blink_mode;
            r_digit   <= w_digit_nxt;
            r_seg     <= w_seg_nxt;
            r_an      <= w_an_nxt;
        end
    end

    assign bus.led_seg = r_seg;
    assign bus.a1      = r_an[0];
    assign bus.a2      = r_an[1];
    assign bus.a3      = r_an[2];
    assign bus.a4      = r_an[3];

endmodule
